regfile_write_arbiter: RTL and testbench

- Shares the single write port of the 32x32 two-read/one-write register file between NUM_REQ producers, for example the ALU writeback, load return and move unit.
- Uses round-robin arbitration with a per-requester valid/ready handshake.
- Registers the winning request onto wrEnable/wrReg/wrData, so the register file always sees a clean, single-source write every cycle.
- Sits between the execution units and the register file write inputs.

---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_write_arbiter_if.sv | 33 +++
 rtl/regfile_write_arbiter_rr_arbiter.sv | 35 +++
 rtl/regfile_write_arbiter.sv | 85 ++++++++
 tb/tb_regfile_write_arbiter.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file constants, the write-request record and a round-robin index helper.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int ZERO_REG   = 0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] regNum;
        logic [REG_DATA_W-1:0] data;
    } wr_req_t;

    function automatic int unsigned rrNext(input int unsigned idx, input int unsigned n);
        return (idx + 1 == n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Requester-side handshake plus the registered register-file write port of the write arbiter.
interface regfile_write_arbiter_if
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = REG_ADDR_W,
    parameter int DATA_W  = REG_DATA_W,
    parameter int CNT_W   = 16
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        reqValid;
    logic [NUM_REQ-1:0]        reqReady;
    logic [NUM_REQ*ADDR_W-1:0] reqReg;
    logic [NUM_REQ*DATA_W-1:0] reqData;
    logic                      stall;
    logic                      wrEnable;
    logic [ADDR_W-1:0]         wrReg;
    logic [DATA_W-1:0]         wrData;
    logic [IDX_W-1:0]          grantId;
    logic [CNT_W-1:0]          wrCount;

    modport master (
        output reqValid, reqReg, reqData, stall,
        input  reqReady, wrEnable, wrReg, wrData, grantId, wrCount
    );

    modport slave (
        input  reqValid, reqReg, reqData, stall,
        output reqReady, wrEnable, wrReg, wrData, grantId, wrCount
    );

endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Purpose: combinational round-robin pick, scanning upward from ptr modulo NUM_REQ.
// Latency: zero cycles, pure combinational.
// Backpressure: en low suppresses the one-hot grant; found/grantIdx still report the candidate.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic               en,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grantIdx,
    output logic               found
);

    int idx;

    always_comb begin
        grant    = '0;
        grantIdx = '0;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && valid[idx]) begin
                found    = 1'b1;
                grantIdx = IDX_W'(idx);
            end
        end
        if (en && found) begin
            grant[grantIdx] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Purpose: round-robin share of the register-file write port among NUM_REQ producers.
// Latency: 1 cycle from acceptance to wrEnable; the register file commits one edge later.
// Backpressure: stall/rst withhold reqReady; REGFILE_ARB_ZERO_GUARD_EN drops writes to register 0.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = REG_ADDR_W,
    parameter int DATA_W  = REG_DATA_W,
    parameter int CNT_W   = 16
) (
    input logic                    clk,
    input logic                    rst,
    regfile_write_arbiter_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef struct packed {
        logic [ADDR_W-1:0] regNum;
        logic [DATA_W-1:0] data;
    } req_t;

    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   winIdx;
    logic [NUM_REQ-1:0] grantVec;
    logic               anyValid;
    logic               xfer;
    logic               commitEn;
    req_t               sel;

    logic               wrEnQ;
    req_t               wrQ;
    logic [IDX_W-1:0]   grantQ;
    logic [CNT_W-1:0]   cntQ;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .valid    (bus.reqValid),
        .en       (!rst && !bus.stall),
        .ptr      (ptr),
        .grant    (grantVec),
        .grantIdx (winIdx),
        .found    (anyValid)
    );

    assign xfer       = anyValid && !rst && !bus.stall;
    assign sel.regNum = bus.reqReg[32'(winIdx)*ADDR_W +: ADDR_W];
    assign sel.data   = bus.reqData[32'(winIdx)*DATA_W +: DATA_W];

`ifdef REGFILE_ARB_ZERO_GUARD_EN
    // Register 0 is hardwired: accept the request but never present the write.
    assign commitEn = (sel.regNum != ADDR_W'(ZERO_REG));
`else
    assign commitEn = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            wrEnQ  <= 1'b0;
            wrQ    <= '0;
            grantQ <= '0;
            ptr    <= '0;
            cntQ   <= '0;
        end else begin
            if (wrEnQ) begin
                cntQ <= cntQ + CNT_W'(1);
            end
            wrEnQ <= xfer && commitEn;
            if (xfer) begin
                wrQ    <= sel;
                grantQ <= winIdx;
                ptr    <= IDX_W'(rrNext(32'(winIdx), NUM_REQ));
            end
        end
    end

    // A write latched just before reset is suppressed so it never reaches the file.
    assign bus.wrEnable = wrEnQ && !rst;
    assign bus.reqReady = grantVec;
    assign bus.wrReg    = wrQ.regNum;
    assign bus.wrData   = wrQ.data;
    assign bus.grantId  = grantQ;
    assign bus.wrCount  = cntQ;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: cycle table, directed write sequences, then randomized traffic vs a queue model.
module tb_regfile_write_arbiter;
    import regfile_pkg::*;

    localparam int N  = 4;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int CW = 16;
    localparam int NV = 25;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_write_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) bus ();

    regfile_write_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

`ifdef REGFILE_ARB_ZERO_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    // Register file fed by the arbiter's write port.
    logic [DW-1:0] rf [32];
    logic          rfReady = 1'b0;
    always @(posedge clk) begin
        if (!rfReady) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'hDEAD_0000 + 32'(i);
            rfReady <= 1'b1;
        end else if (bus.wrEnable) begin
            rf[bus.wrReg] <= bus.wrData;
        end
    end

    typedef struct packed {
        logic        rst;
        logic        stall;
        logic [3:0]  valid;
        logic [3:0]  expReady;
        logic        expWrEn;
        logic [1:0]  expGid;
        logic [15:0] expCnt;
    } vec_t;

    vec_t vecs [NV];

    function automatic vec_t mk(input logic r, input logic s, input logic [3:0] v, input logic [3:0] er,
                                input logic ew, input logic [1:0] eg, input logic [15:0] ec);
        vec_t t;
        t.rst = r; t.stall = s; t.valid = v; t.expReady = er;
        t.expWrEn = ew; t.expGid = eg; t.expCnt = ec;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic setReq(input int i, input logic [AW-1:0] r, input logic [DW-1:0] d);
        bus.reqReg[i*AW +: AW]  = r;
        bus.reqData[i*DW +: DW] = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Random-phase model state
    int            mPtr;
    int            mCnt;
    logic          eWrEn;
    logic [AW-1:0] eReg;
    logic [DW-1:0] eData;
    int            eGid;
    logic          pv [N];
    logic [AW-1:0] pr [N];
    logic [DW-1:0] pd [N];
    int            waitc [N];
    wr_req_t       mRegs [32];
    logic          mWr [32];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int win;
        logic [3:0] er;
        logic st;

        vecs[0]  = mk(1, 0, 4'hF, 4'h0, 0, 0, 0);
        vecs[1]  = mk(0, 0, 4'hF, 4'h1, 0, 0, 0);
        vecs[2]  = mk(0, 0, 4'hF, 4'h2, 1, 0, 0);
        vecs[3]  = mk(0, 0, 4'hF, 4'h4, 1, 1, 1);
        vecs[4]  = mk(0, 0, 4'hF, 4'h8, 1, 2, 2);
        vecs[5]  = mk(0, 0, 4'hF, 4'h1, 1, 3, 3);
        vecs[6]  = mk(0, 0, 4'hF, 4'h2, 1, 0, 4);
        vecs[7]  = mk(0, 0, 4'hF, 4'h4, 1, 1, 5);
        vecs[8]  = mk(0, 0, 4'hF, 4'h8, 1, 2, 6);
        vecs[9]  = mk(0, 1, 4'h3, 4'h0, 1, 3, 7);
        vecs[10] = mk(0, 1, 4'h3, 4'h0, 0, 3, 8);
        vecs[11] = mk(0, 1, 4'h3, 4'h0, 0, 3, 8);
        vecs[12] = mk(0, 0, 4'h3, 4'h1, 0, 3, 8);
        vecs[13] = mk(0, 0, 4'h2, 4'h2, 1, 0, 8);
        vecs[14] = mk(0, 0, 4'h0, 4'h0, 1, 1, 9);
        vecs[15] = mk(0, 0, 4'h0, 4'h0, 0, 1, 10);
        vecs[16] = mk(0, 0, 4'h9, 4'h8, 0, 1, 10);
        vecs[17] = mk(0, 0, 4'h1, 4'h1, 1, 3, 10);
        vecs[18] = mk(0, 0, 4'h5, 4'h4, 1, 0, 11);
        vecs[19] = mk(0, 0, 4'h1, 4'h1, 1, 2, 12);
        vecs[20] = mk(0, 0, 4'h0, 4'h0, 1, 0, 13);
        vecs[21] = mk(0, 0, 4'h0, 4'h0, 0, 0, 14);
        vecs[22] = mk(0, 0, 4'h4, 4'h4, 0, 0, 14);
        vecs[23] = mk(1, 0, 4'h0, 4'h0, 0, 2, 14);
        vecs[24] = mk(0, 0, 4'h0, 4'h0, 0, 0, 0);

        rst = 1'b1;
        bus.stall = 1'b0;
        bus.reqValid = '1;
        for (int i = 0; i < N; i++) setReq(i, AW'(8 + i), DW'(1000 + i));
        #1;
        chk("rst_ready_pre", 64'(bus.reqReady), 64'h0);
        chk("rst_wren_pre", 64'(bus.wrEnable), 64'h0);
        tick();

        for (int r = 0; r < NV; r++) begin
            rst          = vecs[r].rst;
            bus.stall    = vecs[r].stall;
            bus.reqValid = vecs[r].valid;
            #1;
            chk($sformatf("vec%0d_ready", r), 64'(bus.reqReady), 64'(vecs[r].expReady));
            chk($sformatf("vec%0d_wren", r), 64'(bus.wrEnable), 64'(vecs[r].expWrEn));
            chk($sformatf("vec%0d_gid", r), 64'(bus.grantId), 64'(vecs[r].expGid));
            chk($sformatf("vec%0d_cnt", r), 64'(bus.wrCount), 64'(vecs[r].expCnt));
            tick();
        end

        // Single requester 2 writes reg 7
        setReq(2, 5'd7, 32'd70);
        bus.reqValid = 4'b0100;
        #1;
        chk("solo_ready", 64'(bus.reqReady), 64'h4);
        tick();
        bus.reqValid = 4'b0000;
        chk("solo_wren", 64'(bus.wrEnable), 64'h1);
        chk("solo_reg", 64'(bus.wrReg), 64'd7);
        chk("solo_data", 64'(bus.wrData), 64'd70);
        chk("solo_gid", 64'(bus.grantId), 64'd2);
        tick();
        chk("solo_rf7", 64'(rf[7]), 64'd70);

        // Same destination from requesters 1 and 3, pointer reset to 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        setReq(1, 5'd5, 32'd11);
        setReq(3, 5'd5, 32'd33);
        bus.reqValid = 4'b1010;
        #1;
        chk("same_ready1", 64'(bus.reqReady), 64'h2);
        tick();
        bus.reqValid = 4'b1000;
        chk("same_gid1", 64'(bus.grantId), 64'd1);
        chk("same_data1", 64'(bus.wrData), 64'd11);
        #1;
        chk("same_ready3", 64'(bus.reqReady), 64'h8);
        tick();
        bus.reqValid = 4'b0000;
        chk("same_gid3", 64'(bus.grantId), 64'd3);
        chk("same_data3", 64'(bus.wrData), 64'd33);
        tick();
        chk("same_rf5", 64'(rf[5]), 64'd33);
        chk("same_cnt", 64'(bus.wrCount), 64'd2);

        // Write to register 0
        setReq(0, 5'd0, 32'd99);
        bus.reqValid = 4'b0001;
        #1;
        chk("zero_ready", 64'(bus.reqReady), 64'h1);
        tick();
        bus.reqValid = 4'b0000;
        chk("zero_wren", 64'(bus.wrEnable), GUARD ? 64'h0 : 64'h1);
        chk("zero_cnt0", 64'(bus.wrCount), 64'd2);
        tick();
        chk("zero_rf0", 64'(rf[0]), GUARD ? 64'hDEAD_0000 : 64'd99);
        chk("zero_cnt1", 64'(bus.wrCount), GUARD ? 64'd2 : 64'd3);

        // Randomized traffic against the model
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mPtr = 0; mCnt = 0; eWrEn = 1'b0; eReg = '0; eData = '0; eGid = 0;
        for (int i = 0; i < N; i++) begin pv[i] = 1'b0; pr[i] = '0; pd[i] = '0; waitc[i] = 0; end
        for (int i = 0; i < 32; i++) begin mWr[i] = 1'b0; mRegs[i] = '0; end

        for (int cyc = 0; cyc < 400; cyc++) begin
            chk("rnd_wren", 64'(bus.wrEnable), 64'(eWrEn));
            if (eWrEn) begin
                chk("rnd_reg", 64'(bus.wrReg), 64'(eReg));
                chk("rnd_data", 64'(bus.wrData), 64'(eData));
                chk("rnd_gid", 64'(bus.grantId), 64'(eGid));
            end
            chk("rnd_cnt", 64'(bus.wrCount), 64'(mCnt));

            for (int i = 0; i < N; i++) begin
                if (!pv[i] && $urandom_range(0, 1) == 1) begin
                    pv[i] = 1'b1;
                    pr[i] = AW'($urandom_range(0, 31));
                    pd[i] = $urandom;
                    waitc[i] = 0;
                    setReq(i, pr[i], pd[i]);
                end
            end
            st = ($urandom_range(0, 4) == 0);
            bus.stall = st;
            for (int i = 0; i < N; i++) bus.reqValid[i] = pv[i];
            #1;

            win = -1;
            if (!st) begin
                for (int k = 0; k < N; k++) begin
                    if (win < 0 && pv[(mPtr + k) % N]) win = (mPtr + k) % N;
                end
            end
            er = (win >= 0) ? 4'(1 << win) : 4'h0;
            chk("rnd_ready", 64'(bus.reqReady), 64'(er));

            if (eWrEn) mCnt = (mCnt + 1) % (1 << CW);
            if (win >= 0) begin
                chk("rnd_fair", 64'(waitc[win] < N), 64'h1);
                eWrEn = !(GUARD && pr[win] == 0);
                eReg  = pr[win];
                eData = pd[win];
                eGid  = win;
                if (eWrEn) begin
                    mRegs[pr[win]].regNum = pr[win];
                    mRegs[pr[win]].data   = pd[win];
                    mWr[pr[win]] = 1'b1;
                end
                mPtr = (win + 1) % N;
                pv[win] = 1'b0;
            end else begin
                eWrEn = 1'b0;
            end
            if (!st) begin
                for (int i = 0; i < N; i++) if (pv[i] && i != win) waitc[i]++;
            end
            tick();
        end

        bus.reqValid = '0;
        bus.stall = 1'b0;
        tick();
        for (int i = 0; i < 32; i++) begin
            if (mWr[i]) chk($sformatf("rnd_rf%0d", i), 64'(rf[i]), 64'(mRegs[i].data));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
